// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch request controller.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction port between the fetch controller (master) and the bridge (slave).
interface if_fetch_ctrl_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch PC owner: issues one word read at a time, buffers the returned instruction
// for decode, and drops an in-flight response after a redirect.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_inst,
  output logic                  out_adef,
  if_fetch_ctrl_if.master       inst_sram,
  output fetch_state_e          state_dbg
);

  // Handshakes: a request transfers on a cycle with req & addr_ok, and req/addr stay
  // stable until then; read data transfers on any cycle with data_ok; a buffered
  // instruction transfers on out_valid & out_ready, with out_* stable until then.

  fetch_state_e state, state_n;
  logic [31:0]  fetch_pc, fetch_pc_n;
  logic [31:0]  inflight_pc, inflight_pc_n;
  logic         discard, discard_n;
  logic         out_valid_n, out_adef_n;
  logic [31:0]  out_pc_n, out_inst_n;
  logic [31:0]  req_addr;
  logic         req;

  // A redirect during REQ moves fetch_pc but the pending request must not change,
  // so the issued address is parked in inflight_pc while discard is set.
  assign req_addr = (discard && (state == ST_REQ)) ? inflight_pc : fetch_pc;

  always_comb begin
    state_n       = state;
    fetch_pc_n    = redirect_valid ? redirect_pc : fetch_pc;
    inflight_pc_n = inflight_pc;
    discard_n     = discard;
    out_valid_n   = out_valid;
    out_adef_n    = out_adef;
    out_pc_n      = out_pc;
    out_inst_n    = out_inst;
    req           = 1'b0;

    case (state)
      ST_IDLE: begin
        state_n = ST_REQ;
      end

      ST_REQ: begin
        if (req_addr[1:0] == 2'b00) begin
          req = 1'b1;
          if (redirect_valid) begin
            discard_n = 1'b1;
          end
          if (redirect_valid || inst_sram.addr_ok) begin
            inflight_pc_n = req_addr;
          end
          if (inst_sram.addr_ok) begin
            state_n = ST_WAIT;
          end
        end else if (!redirect_valid) begin
          out_valid_n = 1'b1;
          out_adef_n  = 1'b1;
          out_inst_n  = '0;
          out_pc_n    = fetch_pc;
          state_n     = ST_HOLD;
        end
      end

      ST_WAIT: begin
        if (inst_sram.data_ok) begin
          if (discard || redirect_valid) begin
            discard_n = 1'b0;
            state_n   = ST_REQ;
          end else begin
            out_valid_n = 1'b1;
            out_adef_n  = 1'b0;
            out_inst_n  = inst_sram.rdata;
            out_pc_n    = inflight_pc;
            state_n     = ST_HOLD;
          end
        end else if (redirect_valid) begin
          discard_n = 1'b1;
        end
      end

      ST_HOLD: begin
        // Redirect beats a simultaneous consume: the flush covers that instruction.
        if (redirect_valid) begin
          out_valid_n = 1'b0;
          state_n     = ST_REQ;
        end else if (out_ready) begin
          out_valid_n = 1'b0;
          fetch_pc_n  = fetch_pc + PC_STEP;
          state_n     = ST_REQ;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      discard     <= 1'b0;
      out_valid   <= 1'b0;
      out_adef    <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      inflight_pc <= inflight_pc_n;
      discard     <= discard_n;
      out_valid   <= out_valid_n;
      out_adef    <= out_adef_n;
      out_pc      <= out_pc_n;
      out_inst    <= out_inst_n;
    end
  end

  assign inst_sram.req   = req;
  assign inst_sram.addr  = req_addr;
  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = SIZE_WORD;
  assign inst_sram.wstrb = 4'h0;
  assign inst_sram.wdata = 32'h0;
  assign state_dbg       = state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a small SRAM-like memory model with adjustable address
// stall and read latency, directed sequences and a table of redirect vectors.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [31:0]  out_pc;
  logic [31:0]  out_inst;
  logic         out_adef;
  fetch_state_e state_dbg;

  if_fetch_ctrl_if bus();

  int errors = 0;
  int checks = 0;

  // memory model controls, written only by the main sequence
  int stall_cfg = 0;
  int dlat_cfg  = 2;

  logic        pend;
  logic        data_ok_r;
  logic [31:0] rdata_r;
  logic [31:0] paddr;
  int          stall_cnt;
  int          lat_cnt;

  always #5 aclk = ~aclk;

  if_fetch_ctrl dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_adef       (out_adef),
    .inst_sram      (bus),
    .state_dbg      (state_dbg)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0404;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.addr_ok = bus.req && !pend && (stall_cnt >= stall_cfg);
  assign bus.data_ok = data_ok_r;
  assign bus.rdata   = rdata_r;

  always @(posedge aclk) begin
    data_ok_r <= 1'b0;
    if (!aresetn) begin
      pend      <= 1'b0;
      stall_cnt <= 0;
      lat_cnt   <= 0;
      rdata_r   <= 32'h0;
      paddr     <= 32'h0;
    end else begin
      if (bus.req && !pend) begin
        if (bus.addr_ok) begin
          pend      <= 1'b1;
          lat_cnt   <= dlat_cfg;
          paddr     <= bus.addr;
          stall_cnt <= 0;
        end else begin
          stall_cnt <= stall_cnt + 1;
        end
      end
      if (pend) begin
        if (lat_cnt <= 1) begin
          data_ok_r <= 1'b1;
          rdata_r   <= mem_word(paddr);
          pend      <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] target;
    int          stall;
    int          dlat;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_adef;
    logic        exp_req;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int k);
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles, expected event did not occur", name, k);
  endtask

  // Waits (bounded) for out_valid; counts cycles with req high while waiting.
  task automatic wait_out(input string name, output int n_req);
    int k;
    k = 0;
    n_req = 0;
    while (!out_valid && k < 60) begin
      if (bus.req) n_req++;
      @(negedge aclk);
      k++;
    end
    if (!out_valid) bound_fail(name, k);
  endtask

  // Waits (bounded) for req; counts cycles with out_valid high while waiting.
  task automatic wait_req(input string name, output int n_ov);
    int k;
    k = 0;
    n_ov = 0;
    while (!bus.req && k < 60) begin
      if (out_valid) n_ov++;
      @(negedge aclk);
      k++;
    end
    if (!bus.req) bound_fail(name, k);
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge aclk);
    redirect_valid = 1'b0;
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(negedge aclk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n_req;
    int n_ov;
    int k;

    vecs[0] = '{32'h1c00_0200, 2, 3, 32'h1c00_0200, 32'h0200_fdff, 1'b0, 1'b1};
    vecs[1] = '{32'h1c00_0010, 0, 1, 32'h1c00_0010, 32'h0010_ffef, 1'b0, 1'b1};
    vecs[2] = '{32'h1c00_0003, 0, 2, 32'h1c00_0003, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0008, 1, 2, 32'h0000_0008, 32'h0008_fff7, 1'b0, 1'b1};
    vecs[4] = '{32'h1c00_0002, 0, 2, 32'h1c00_0002, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'hffff_fffc, 1, 2, 32'hffff_fffc, 32'hfffc_0003, 1'b0, 1'b1};

    // reset state
    aresetn   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge aclk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_adef", 32'(out_adef), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("const_wr", 32'(bus.wr), 32'd0);
    check("const_size", 32'(bus.size), 32'd2);
    check("const_wstrb", 32'(bus.wstrb), 32'd0);
    check("const_wdata", bus.wdata, 32'h0);

    // first fetch after release
    aresetn = 1'b1;
    @(negedge aclk);
    check("first_req", 32'(bus.req), 32'd1);
    check("first_addr", bus.addr, 32'h1c00_0000);
    wait_out("first_out", n_req);
    check("first_out_pc", out_pc, 32'h1c00_0000);
    check("first_out_inst", out_inst, 32'h0280_0404);
    check("first_out_adef", 32'(out_adef), 32'd0);
    wait_req("second_req", n_ov);
    check("second_addr", bus.addr, 32'h1c00_0004);

    // decode back-pressure
    out_ready = 1'b0;
    wait_out("stall_out", n_req);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pc", out_pc, 32'h1c00_0004);
      check("hold_inst", out_inst, 32'h0004_fffb);
      check("hold_no_req", 32'(bus.req), 32'd0);
    end
    dlat_cfg  = 4;
    out_ready = 1'b1;
    @(negedge aclk);
    check("advance_req", 32'(bus.req), 32'd1);
    check("advance_addr", bus.addr, 32'h1c00_0008);

    // redirect while waiting for data
    k = 0;
    while (state_dbg != ST_WAIT && k < 20) begin
      @(negedge aclk);
      k++;
    end
    if (state_dbg != ST_WAIT) bound_fail("reach_wait", k);
    pulse_redirect(32'h1c00_0100);
    wait_req("wait_redir_req", n_ov);
    dlat_cfg = 2;
    check("wait_redir_no_out", 32'(n_ov), 32'd0);
    check("wait_redir_addr", bus.addr, 32'h1c00_0100);
    wait_out("wait_redir_out", n_req);
    check("wait_redir_pc", out_pc, 32'h1c00_0100);
    check("wait_redir_inst", out_inst, 32'h0100_feff);

    // redirect in the same cycle as data_ok
    k = 0;
    while (!bus.data_ok && k < 20) begin
      @(negedge aclk);
      k++;
    end
    if (!bus.data_ok) bound_fail("reach_data_ok", k);
    pulse_redirect(32'h1c00_0040);
    wait_req("dok_redir_req", n_ov);
    check("dok_redir_no_out", 32'(n_ov), 32'd0);
    check("dok_redir_addr", bus.addr, 32'h1c00_0040);
    wait_out("dok_redir_out", n_req);
    check("dok_redir_pc", out_pc, 32'h1c00_0040);
    check("dok_redir_inst", out_inst, 32'h0040_ffbf);

    // redirect while the address is stalled
    stall_cfg = 4;
    @(negedge aclk);
    wait_req("stall_req", n_ov);
    check("stall_addr", bus.addr, 32'h1c00_0044);
    pulse_redirect(32'h1c00_0300);
    k = 0;
    while (!bus.addr_ok && k < 20) begin
      check("stall_req_held", 32'(bus.req), 32'd1);
      check("stall_addr_held", bus.addr, 32'h1c00_0044);
      @(negedge aclk);
      k++;
    end
    check("stall_accept_addr", bus.addr, 32'h1c00_0044);
    stall_cfg = 0;
    @(negedge aclk);
    wait_req("stall_redir_req", n_ov);
    check("stall_redir_no_out", 32'(n_ov), 32'd0);
    check("stall_redir_addr", bus.addr, 32'h1c00_0300);
    out_ready = 1'b0;
    wait_out("stall_redir_out", n_req);
    check("stall_redir_pc", out_pc, 32'h1c00_0300);
    check("stall_redir_inst", out_inst, 32'h0300_fcff);

    // table of redirects issued from HOLD
    for (int i = 0; i < NV; i++) begin
      stall_cfg = vecs[i].stall;
      dlat_cfg  = vecs[i].dlat;
      pulse_redirect(vecs[i].target);
      wait_out("vec_out", n_req);
      check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_adef", i), 32'(out_adef), 32'(vecs[i].exp_adef));
      check($sformatf("vec%0d_req", i), 32'(n_req != 0), 32'(vecs[i].exp_req));
    end
    stall_cfg = 0;
    dlat_cfg  = 2;

    // PC wraps from 0xfffffffc to 0
    pulse_ready();
    wait_out("wrap_out", n_req);
    check("wrap_pc", out_pc, 32'h0);
    check("wrap_inst", out_inst, 32'h0000_ffff);
    check("wrap_adef", 32'(out_adef), 32'd0);

    // misaligned target keeps faulting after consumption
    pulse_redirect(32'h1c00_0102);
    wait_out("adef_out", n_req);
    check("adef_pc", out_pc, 32'h1c00_0102);
    check("adef_flag", 32'(out_adef), 32'd1);
    check("adef_inst", out_inst, 32'h0);
    check("adef_no_req", 32'(n_req), 32'd0);
    pulse_ready();
    wait_out("adef2_out", n_req);
    check("adef2_pc", out_pc, 32'h1c00_0106);
    check("adef2_flag", 32'(out_adef), 32'd1);
    check("adef2_no_req", 32'(n_req), 32'd0);

    // synchronous reset in the middle of operation
    pulse_redirect(32'h1c00_0500);
    out_ready = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_req", 32'(bus.req), 32'd0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid_rst_first_req", 32'(bus.req), 32'd1);
    check("mid_rst_first_addr", bus.addr, 32'h1c00_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
